// File: rtl/cfu_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cfu_fifo_pkg
//  Brief    : Shared width helpers for the multi-channel CFU FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package cfu_fifo_pkg;

    // Width of a channel index; a single-channel build still needs one bit.
    function automatic int ch_idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Width of an occupancy counter; one extra bit so DEPTH itself fits.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfu_fifo_channel.sv
`default_nettype none
// ============================================================================
//  Module   : cfu_fifo_channel
//  Brief    : One first-word-fall-through queue: storage, pointers, counter,
//             full/valid and optional sticky error flags.
//             Optional feature macro: CFU_FIFO_ERROR_EN (overflow/underflow).
//  Revision : 1.0 - initial release
// ============================================================================
module cfu_fifo_channel
    import cfu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 42,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          potential_push,
    input  logic                          pop,
    input  logic                          err_clear,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid,
    output logic                          full,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int c_aw     = $clog2(DEPTH);
    localparam int c_cnt_w  = count_width(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic w_is_full;
    logic w_is_empty;
    logic w_push_acc;
    logic w_pop_acc;

    // A pop on a full queue frees the slot this same edge, so the push may land.
    assign w_is_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_is_empty = (r_count == '0);
    assign w_push_acc = push && (!w_is_full || pop);
    assign w_pop_acc  = pop && !w_is_empty;

    // Storage is deliberately left unreset; valid gates its meaning.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_out = r_mem[r_rd_ptr];
    assign valid    = !w_is_empty;
    assign count    = r_count;
    // Early full: one slot left and the producer has announced a push here.
    assign full     = w_is_full ||
                      ((r_count == c_cnt_w'(DEPTH - 1)) && potential_push);

`ifdef CFU_FIFO_ERROR_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_evt;
    logic w_unf_evt;

    assign w_ovf_evt = push && w_is_full && !pop;
    assign w_unf_evt = pop && w_is_empty;

    // Sticky error flags; a new event outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (err_clear) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (err_clear) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clear;
    assign w_unused_err_clear = err_clear;
    assign overflow           = 1'b0;
    assign underflow          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/cfu_fifo_mc.sv
`default_nettype none
// ============================================================================
//  Module   : cfu_fifo_mc
//  Brief    : CHANNELS independent FWFT queues sharing one steered push port,
//             with a separate pop port per channel.
//             Optional feature macro: CFU_FIFO_ERROR_EN (overflow/underflow).
//  Revision : 1.0 - initial release
// ============================================================================
module cfu_fifo_mc
    import cfu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 42,
    parameter int DEPTH      = 4,
    parameter int CHANNELS   = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   push,
    input  logic [ch_idx_width(CHANNELS)-1:0]      push_ch,
    input  logic [DATA_WIDTH-1:0]                  data_in,
    input  logic                                   potential_push,
    input  logic [CHANNELS-1:0]                    pop,
    output logic [CHANNELS*DATA_WIDTH-1:0]         data_out,
    output logic [CHANNELS-1:0]                    valid,
    output logic [CHANNELS-1:0]                    full,
    output logic [CHANNELS*count_width(DEPTH)-1:0] count,
    output logic [CHANNELS-1:0]                    overflow,
    output logic [CHANNELS-1:0]                    underflow,
    input  logic                                   err_clear
);

    localparam int c_ch_w  = ch_idx_width(CHANNELS);
    localparam int c_cnt_w = count_width(DEPTH);

    // An index at or beyond CHANNELS matches no channel, so such a push is
    // silently dropped without touching any queue or flag.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic w_sel;
        assign w_sel = (push_ch == c_ch_w'(g));

        cfu_fifo_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_chan (
            .clk            (clk),
            .rst_n          (rst_n),
            .push           (push && w_sel),
            .data_in        (data_in),
            .potential_push (potential_push && w_sel),
            .pop            (pop[g]),
            .err_clear      (err_clear),
            .data_out       (data_out[g*DATA_WIDTH +: DATA_WIDTH]),
            .valid          (valid[g]),
            .full           (full[g]),
            .count          (count[g*c_cnt_w +: c_cnt_w]),
            .overflow       (overflow[g]),
            .underflow      (underflow[g])
        );
    end

endmodule
`default_nettype wire
